// File: rtl/maxpool2x2_stream_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : maxpool2x2_stream_ctrl
// Purpose  : Streaming 2x2 / stride-2 max-pool for 8-bit minifloat pixels
//            (1 sign, 4 exponent, 3 mantissa bits). Pixels arrive one per
//            cycle in raster order. Horizontal pair maxima of each even row
//            go into a half-width line buffer. On the following odd row they
//            are combined with that row's pair maxima to produce one pooled
//            pixel per 2x2 window.
// Ports    : clk        rising-edge clock
//            rst        asynchronous reset, active-high
//            in_valid   input pixel valid
//            in_ready   input ready (low only while a result is held)
//            in_data    input pixel, raster order
//            out_valid  pooled pixel valid
//            out_ready  downstream ready
//            out_data   pooled pixel
//            out_last   final pooled pixel of the frame
// Revision : 1.0 - initial release
// ============================================================================
module maxpool2x2_stream_ctrl #(
    parameter int DATA_BITS = 8,
    parameter int IMG_W     = 48,
    parameter int IMG_H     = 48
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [DATA_BITS-1:0] in_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [DATA_BITS-1:0] out_data,
    output logic                 out_last
);

    localparam int c_COL_W     = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int c_ROW_W     = (IMG_H > 1) ? $clog2(IMG_H) : 1;
    localparam int c_BUF_DEPTH = IMG_W / 2;
    localparam int c_BUF_AW    = (c_BUF_DEPTH > 1) ? $clog2(c_BUF_DEPTH) : 1;

    localparam logic [c_COL_W-1:0] c_COL_LAST = c_COL_W'(IMG_W - 1);
    localparam logic [c_ROW_W-1:0] c_ROW_LAST = c_ROW_W'(IMG_H - 1);

    typedef enum logic [0:0] {
        ROW_EVEN = 1'b0,
        ROW_ODD  = 1'b1
    } rowState_t;

    rowState_t            r_state;
    logic [c_COL_W-1:0]   r_col;
    logic [c_ROW_W-1:0]   r_row;
    logic [DATA_BITS-1:0] r_pairReg;
    logic [DATA_BITS-1:0] r_lineBuf [c_BUF_DEPTH];

    logic                 w_accept;
    logic                 w_colOdd;
    logic                 w_colLast;
    logic                 w_rowLast;
    logic                 w_load;
    logic                 w_bufWrite;
    logic [c_BUF_AW-1:0]  w_bufIdx;
    logic [DATA_BITS-1:0] w_hMax;
    logic [DATA_BITS-1:0] w_poolMax;

    // Sign-magnitude maximum. With both signs equal the magnitude decides
    // (inverted for negatives); mixed signs pick the positive operand.
    // Ties return a, and since +0 and -0 differ in sign, +0 always wins.
    function automatic logic [DATA_BITS-1:0] fpMax(
        input logic [DATA_BITS-1:0] a,
        input logic [DATA_BITS-1:0] b
    );
        logic [DATA_BITS-1:0] res;
        res = a;
        case ({a[DATA_BITS-1], b[DATA_BITS-1]})
            2'b00:   res = (b[DATA_BITS-2:0] > a[DATA_BITS-2:0]) ? b : a;
            2'b01:   res = a;
            2'b10:   res = b;
            default: res = (b[DATA_BITS-2:0] < a[DATA_BITS-2:0]) ? b : a;
        endcase
        return res;
    endfunction

    // Stall only while a result is held and not yet taken downstream.
    assign in_ready   = ~(out_valid & ~out_ready);
    assign w_accept   = in_valid & in_ready;

    assign w_colOdd   = r_col[0];
    assign w_colLast  = (r_col == c_COL_LAST);
    assign w_rowLast  = (r_row == c_ROW_LAST);
    assign w_bufIdx   = c_BUF_AW'(r_col >> 1);

    assign w_hMax     = fpMax(r_pairReg, in_data);
    assign w_poolMax  = fpMax(r_lineBuf[w_bufIdx], w_hMax);

    assign w_bufWrite = w_accept & w_colOdd & (r_state == ROW_EVEN);
    assign w_load     = w_accept & w_colOdd & (r_state == ROW_ODD);

    // Counters, row-parity FSM, pair register and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= ROW_EVEN;
            r_col     <= '0;
            r_row     <= '0;
            r_pairReg <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_last  <= 1'b0;
        end else begin
            if (w_accept) begin
                if (!w_colOdd) begin
                    r_pairReg <= in_data;
                end
                if (w_colLast) begin
                    r_col <= '0;
                    if (w_rowLast) begin
                        r_row   <= '0;
                        r_state <= ROW_EVEN;
                    end else begin
                        r_row   <= r_row + 1'b1;
                        r_state <= (r_state == ROW_EVEN) ? ROW_ODD : ROW_EVEN;
                    end
                end else begin
                    r_col <= r_col + 1'b1;
                end
            end

            // A new result can only load when in_ready is high, so loading
            // never overwrites a held result; it may replace one being taken.
            if (w_load) begin
                out_valid <= 1'b1;
                out_data  <= w_poolMax;
                out_last  <= w_rowLast & w_colLast;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

    // Line buffer holds even-row pair maxima; contents need no reset since
    // every entry is written before the odd row reads it.
    always_ff @(posedge clk) begin
        if (w_bufWrite) begin
            r_lineBuf[w_bufIdx] <= w_hMax;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_maxpool2x2_stream_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_maxpool2x2_stream_ctrl
// Purpose  : Self-checking bench for maxpool2x2_stream_ctrl on a 4x4 frame.
//            Expected pooled pixels come from a value-based window maximum
//            over whole frames held in arrays.
// Revision : 1.0 - initial release
// ============================================================================
module tb_maxpool2x2_stream_ctrl;

    localparam int W    = 4;
    localparam int H    = 4;
    localparam int NPIX = W * H;
    localparam int NOUT = NPIX / 4;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_data;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_data;
    logic       out_last;

    int total = 0;
    int bad   = 0;

    logic [8:0] outQ[$];
    logic [8:0] expQ[$];
    logic [7:0] frm  [NPIX];
    logic [7:0] spec2[NPIX] = '{8'h38, 8'h40, 8'h30, 8'h28,
                                8'h48, 8'h00, 8'h20, 8'h18,
                                8'hB8, 8'hC0, 8'h80, 8'h00,
                                8'hB0, 8'hC8, 8'h88, 8'h90};

    maxpool2x2_stream_ctrl #(.DATA_BITS(8), .IMG_W(W), .IMG_H(H)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_last  (out_last)
    );

    always #5 clk = ~clk;

    // Record every output transfer (values are stable at the falling edge).
    always @(negedge clk) begin
        if (rst === 1'b0 && out_valid === 1'b1 && out_ready === 1'b1)
            outQ.push_back({out_last, out_data});
    end

    // ---------------- reference model ----------------
    function automatic int sval(input logic [7:0] p);
        return p[7] ? -int'({1'b0, p[6:0]}) : int'({1'b0, p[6:0]});
    endfunction

    // Largest numeric value of the window; among zeros, +0 wins over -0.
    function automatic logic [7:0] winMax(input logic [7:0] a, input logic [7:0] b,
                                          input logic [7:0] c, input logic [7:0] d);
        logic [7:0] v[4];
        logic [7:0] best;
        v[0] = a; v[1] = b; v[2] = c; v[3] = d;
        best = a;
        for (int i = 1; i < 4; i++) begin
            if (sval(v[i]) > sval(best) || (sval(v[i]) == sval(best) && v[i] == 8'h00))
                best = v[i];
        end
        return best;
    endfunction

    task automatic buildExp();
        expQ.delete();
        for (int wr = 0; wr < H / 2; wr++) begin
            for (int wc = 0; wc < W / 2; wc++) begin
                int b;
                b = 2 * wr * W + 2 * wc;
                expQ.push_back({(wr == H / 2 - 1) && (wc == W / 2 - 1),
                                winMax(frm[b], frm[b + 1], frm[b + W], frm[b + W + 1])});
            end
        end
    endtask

    // ---------------- driver ----------------
    task automatic sendFrame(input int validPct, input int readyPct);
        int idx = 0;
        int cyc = 0;
        while (idx < NPIX && cyc < 500) begin
            in_valid  = ($urandom_range(99) < validPct);
            in_data   = frm[idx];
            out_ready = ($urandom_range(99) < readyPct);
            @(negedge clk);
            if (in_valid && in_ready) idx++;
            @(posedge clk); #1;
            cyc++;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        total++;
        if (idx != NPIX) begin
            bad++;
            $display("FAIL sendFrame_timeout accepted=%0d required=%0d", idx, NPIX);
        end
    endtask

    task automatic drain();
        repeat (3) begin @(posedge clk); #1; end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        in_valid = 1'b0; in_data = 8'h00; out_ready = 1'b1; rst = 1'b0;
        @(posedge clk); #3;
        rst = 1'b1;
        #1;
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
        total++; if (out_data !== 8'h00) begin bad++; $display("FAIL reset_out_data got=%h exp=00", out_data); end
        total++; if (out_last !== 1'b0) begin bad++; $display("FAIL reset_out_last got=%b exp=0", out_last); end
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_basic();
        frm = spec2;
        buildExp();
        outQ.delete();
        out_ready = 1'b1;
        for (int i = 0; i < NPIX; i++) begin
            logic expV;
            in_valid = 1'b1;
            in_data  = spec2[i];
            @(negedge clk);
            total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL basic_in_ready pix=%0d got=%b exp=1", i, in_ready); end
            @(posedge clk); #1;
            expV = ((i / W) % 2 == 1) && ((i % W) % 2 == 1);
            total++; if (out_valid !== expV) begin bad++; $display("FAIL basic_latency pix=%0d got=%b exp=%b", i, out_valid, expV); end
        end
        in_valid = 1'b0;
        drain();
        total++; if (outQ.size() != NOUT) begin bad++; $display("FAIL basic_count got=%0d exp=%0d", outQ.size(), NOUT); end
        for (int k = 0; k < expQ.size() && k < outQ.size(); k++) begin
            total++; if (outQ[k] !== expQ[k]) begin bad++; $display("FAIL basic_out k=%0d got=%h exp=%h", k, outQ[k], expQ[k]); end
        end
    endtask

    task automatic test_neg_zero();
        logic [8:0] e[4];
        frm = '{8'hB8, 8'hC0, 8'h80, 8'h00,
                8'hC8, 8'hB8, 8'h80, 8'h80,
                8'h80, 8'h80, 8'h00, 8'h00,
                8'h80, 8'h80, 8'h00, 8'h00};
        for (int i = 0; i < 4; i++) frm[10 + (i / 2) * W + (i % 2)] = 8'($urandom);
        e[0] = 9'h0B8; e[1] = 9'h000; e[2] = 9'h080;
        e[3] = {1'b1, winMax(frm[10], frm[11], frm[14], frm[15])};
        outQ.delete();
        sendFrame(100, 100);
        drain();
        total++; if (outQ.size() != NOUT) begin bad++; $display("FAIL negzero_count got=%0d exp=%0d", outQ.size(), NOUT); end
        for (int k = 0; k < 4 && k < outQ.size(); k++) begin
            total++; if (outQ[k] !== e[k]) begin bad++; $display("FAIL negzero_out k=%0d got=%h exp=%h", k, outQ[k], e[k]); end
        end
    endtask

    task automatic test_backpressure();
        int idx = 0;
        int stall = 0;
        int cyc = 0;
        frm = spec2;
        buildExp();
        outQ.delete();
        out_ready = 1'b0;
        while (idx < NPIX && cyc < 200) begin
            in_valid = 1'b1;
            in_data  = frm[idx];
            @(negedge clk);
            if (out_valid && !out_ready) begin
                stall++;
                total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL bp_in_ready got=%b exp=0", in_ready); end
                total++; if (out_data !== 8'h48) begin bad++; $display("FAIL bp_hold_data got=%h exp=48", out_data); end
                total++; if (idx != 6) begin bad++; $display("FAIL bp_accepts got=%0d exp=6", idx); end
            end
            if (in_valid && in_ready) idx++;
            @(posedge clk); #1;
            if (stall >= 3) out_ready = 1'b1;
            cyc++;
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        drain();
        total++; if (stall != 3) begin bad++; $display("FAIL bp_stall_cycles got=%0d exp=3", stall); end
        total++; if (outQ.size() != NOUT) begin bad++; $display("FAIL bp_count got=%0d exp=%0d", outQ.size(), NOUT); end
        for (int k = 0; k < expQ.size() && k < outQ.size(); k++) begin
            total++; if (outQ[k] !== expQ[k]) begin bad++; $display("FAIL bp_out k=%0d got=%h exp=%h", k, outQ[k], expQ[k]); end
        end
    endtask

    task automatic test_back_to_back();
        int acc = 0;
        frm = spec2;
        buildExp();
        for (int k = 0; k < NOUT; k++) expQ.push_back(expQ[k]);
        outQ.delete();
        out_ready = 1'b1;
        for (int i = 0; i < 2 * NPIX; i++) begin
            in_valid = 1'b1;
            in_data  = spec2[i % NPIX];
            @(negedge clk);
            if (in_ready) acc++;
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        drain();
        total++; if (acc != 2 * NPIX) begin bad++; $display("FAIL b2b_accepts got=%0d exp=%0d", acc, 2 * NPIX); end
        total++; if (outQ.size() != 2 * NOUT) begin bad++; $display("FAIL b2b_count got=%0d exp=%0d", outQ.size(), 2 * NOUT); end
        for (int k = 0; k < expQ.size() && k < outQ.size(); k++) begin
            total++; if (outQ[k] !== expQ[k]) begin bad++; $display("FAIL b2b_out k=%0d got=%h exp=%h", k, outQ[k], expQ[k]); end
        end
    endtask

    task automatic test_mid_reset();
        out_ready = 1'b0;
        for (int i = 0; i < 6; i++) begin
            in_valid = 1'b1;
            in_data  = 8'($urandom);
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL midrst_pending got=%b exp=1", out_valid); end
        #3;
        rst = 1'b1;
        #1;
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL midrst_out_valid got=%b exp=0", out_valid); end
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL midrst_in_ready got=%b exp=1", in_ready); end
        @(posedge clk); #1;
        rst = 1'b0;
        out_ready = 1'b1;
        frm = spec2;
        buildExp();
        outQ.delete();
        sendFrame(100, 100);
        drain();
        total++; if (outQ.size() != NOUT) begin bad++; $display("FAIL midrst_count got=%0d exp=%0d", outQ.size(), NOUT); end
        for (int k = 0; k < expQ.size() && k < outQ.size(); k++) begin
            total++; if (outQ[k] !== expQ[k]) begin bad++; $display("FAIL midrst_out k=%0d got=%h exp=%h", k, outQ[k], expQ[k]); end
        end
    endtask

    task automatic test_random();
        for (int f = 0; f < 6; f++) begin
            for (int i = 0; i < NPIX; i++)
                frm[i] = ($urandom_range(7) == 0) ? (($urandom_range(1) == 0) ? 8'h80 : 8'h00)
                                                  : 8'($urandom);
            buildExp();
            outQ.delete();
            sendFrame(70, 60);
            drain();
            total++; if (outQ.size() != NOUT) begin bad++; $display("FAIL rand_count frame=%0d got=%0d exp=%0d", f, outQ.size(), NOUT); end
            for (int k = 0; k < expQ.size() && k < outQ.size(); k++) begin
                total++; if (outQ[k] !== expQ[k]) begin bad++; $display("FAIL rand_out frame=%0d k=%0d got=%h exp=%h", f, k, outQ[k], expQ[k]); end
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_neg_zero();
        test_backpressure();
        test_back_to_back();
        test_mid_reset();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
